// File: rtl/modmul_pkg.sv
// Shared helpers for the pseudo-Mersenne modular multiplier (P = 2^N - C).
// Parameter-dependent constants are derived through these functions by each instance.
package modmul_pkg;

  // Modulus value for a given N/C pair.
  function automatic int calc_p(input int n, input int c);
    return (1 << n) - c;
  endfunction

  // First fold needs room for lo + C*hi with one guard bit.
  function automatic int calc_f1_w(input int n, input int c);
    return n + $clog2(c + 1) + 1;
  endfunction

  // Second fold is bounded below 2P, so one extra bit suffices.
  function automatic int calc_f2_w(input int n);
    return n + 1;
  endfunction

  // Legal pairs guarantee f2 < 2P, so a single conditional subtract finishes the reduction.
  function automatic bit c_ok(input int n, input int c);
    return (n >= 3) && (n <= 31) && (c >= 1) && ((c * (c + 2)) < (1 << n));
  endfunction

  // One pseudo-Mersenne fold: low N bits plus C times everything above.
  function automatic logic [63:0] pm_fold(input logic [63:0] x, input int n, input int c);
    logic [63:0] mask;
    mask = (64'd1 << n) - 64'd1;
    return (x & mask) + (64'(c) * (x >> n));
  endfunction

endpackage

// File: rtl/modmul_pipe_stage.sv
// One {valid, data} pipeline register with elastic ready/hold behaviour.
// A stage accepts new content whenever it is empty or its downstream is draining it.
module modmul_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         down_ready,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_r;
  logic [W-1:0] data_r;

  assign ready = ~valid_r | down_ready;
  assign valid = valid_r;
  assign data  = data_r;

  // Load from upstream when ready (bubbles included), otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= 1'b0;
      data_r  <= {W{1'b0}};
    end else if (ready) begin
      valid_r <= up_valid;
      data_r  <= up_data;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

endmodule

// File: rtl/modmul_pm_pipe.sv
// Three-stage pipelined m = (a*b) mod (2^N - C) with valid/ready backpressure.
// Optional sideband tag travelling with each operand pair: define MODMUL_TAG_EN.
import modmul_pkg::*;

module modmul_pm_pipe #(
  parameter int N = 5,
  parameter int C = 3
`ifdef MODMUL_TAG_EN
  ,
  parameter int TAG_W = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
`ifdef MODMUL_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     m
);

  localparam int P    = calc_p(N, C);
  localparam int F1_W = calc_f1_w(N, C);
  localparam int F2_W = calc_f2_w(N);
`ifdef MODMUL_TAG_EN
  localparam int TW = TAG_W;
`else
  localparam int TW = 0;
`endif
  localparam int S1_W = TW + 2 * N;
  localparam int S2_W = TW + F1_W;
  localparam int S3_W = TW + N;
  localparam logic [F2_W-1:0] P_W = F2_W'(P);

  if (!c_ok(N, C)) begin : g_param_check
    $fatal(1, "modmul_pm_pipe: N/C pair violates C*(C+2) < 2^N");
  end

  logic [2*N-1:0]  prod_s;
  logic [F1_W-1:0] f1_s;
  logic [F2_W-1:0] f2_s;
  logic [N-1:0]    m_next_s;
  logic [S1_W-1:0] s1_in_s, s1_data_s;
  logic [S2_W-1:0] s2_in_s, s2_data_s;
  logic [S3_W-1:0] s3_in_s, s3_data_s;
  logic            s1_valid_s, s2_valid_s;
  logic            rdy2_s, rdy3_s;

  // Stage-1 input: full-width product of the raw operands.
  always_comb begin
    prod_s = {{N{1'b0}}, a} * {{N{1'b0}}, b};
`ifdef MODMUL_TAG_EN
    s1_in_s = {in_tag, prod_s};
`else
    s1_in_s = prod_s;
`endif
  end

  // Stage-2 input: first fold of the registered product.
  always_comb begin
    f1_s = F1_W'(pm_fold(64'(s1_data_s[2*N-1:0]), N, C));
`ifdef MODMUL_TAG_EN
    s2_in_s = {s1_data_s[S1_W-1 -: TW], f1_s};
`else
    s2_in_s = f1_s;
`endif
  end

  // Stage-3 input: second fold, then one conditional subtract to reach [0, P).
  always_comb begin
    f2_s = F2_W'(pm_fold(64'(s2_data_s[F1_W-1:0]), N, C));
    if (f2_s >= P_W) begin
      m_next_s = N'(f2_s - P_W);
    end else begin
      m_next_s = N'(f2_s);
    end
`ifdef MODMUL_TAG_EN
    s3_in_s = {s2_data_s[S2_W-1 -: TW], m_next_s};
`else
    s3_in_s = m_next_s;
`endif
  end

  modmul_pipe_stage #(.W(S1_W)) u_s1 (
    .clk(clk), .reset(reset),
    .up_valid(in_valid), .up_data(s1_in_s), .down_ready(rdy2_s),
    .ready(in_ready), .valid(s1_valid_s), .data(s1_data_s)
  );

  modmul_pipe_stage #(.W(S2_W)) u_s2 (
    .clk(clk), .reset(reset),
    .up_valid(s1_valid_s), .up_data(s2_in_s), .down_ready(rdy3_s),
    .ready(rdy2_s), .valid(s2_valid_s), .data(s2_data_s)
  );

  modmul_pipe_stage #(.W(S3_W)) u_s3 (
    .clk(clk), .reset(reset),
    .up_valid(s2_valid_s), .up_data(s3_in_s), .down_ready(out_ready),
    .ready(rdy3_s), .valid(out_valid), .data(s3_data_s)
  );

  assign m = s3_data_s[N-1:0];
`ifdef MODMUL_TAG_EN
  assign out_tag = s3_data_s[S3_W-1 -: TW];
`endif

endmodule

// File: tb/tb_modmul_pm_pipe.sv
// Directed and streaming checks for modmul_pm_pipe at N=5/C=3 (P=29) and N=8/C=5 (P=251).
// Tag alignment is exercised only when MODMUL_TAG_EN is defined.
module tb_modmul_pm_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [4:0] a = 5'd0, b = 5'd0, m;
  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
  logic [7:0] a8 = 8'd0, b8 = 8'd0, m8;
`ifdef MODMUL_TAG_EN
  logic [3:0] in_tag = 4'd0, out_tag, in_tag8 = 4'd0, out_tag8;
`endif

  int n_vec = 0;
  int n_err = 0;
  int sb[$];
  bit mon_en = 1'b0;
  bit prev_stall = 1'b0;
  int prev_m = 0;
  int rcv = 0;
  int ir_drops = 0;
  bit stream_mode = 1'b0;
  bit rnd_done = 1'b0;

  always #5 clk = ~clk;

  modmul_pm_pipe #(.N(5), .C(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
`ifdef MODMUL_TAG_EN
    .in_tag(in_tag), .out_tag(out_tag),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .m(m)
  );

  modmul_pm_pipe #(.N(8), .C(5)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8),
`ifdef MODMUL_TAG_EN
    .in_tag(in_tag8), .out_tag(out_tag8),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8), .m(m8)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check_eq("stall_valid_hold", int'(out_valid), 1);
        check_eq("stall_m_hold", int'(m), prev_m);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_result_sb_size", sb.size(), 1);
        end else begin
          check_eq("stream_m", int'(m), sb.pop_front());
          rcv++;
        end
      end
      if (in_valid && in_ready) sb.push_back((int'(a) * int'(b)) % 29);
      if (stream_mode && !in_ready) ir_drops++;
      prev_stall = out_valid && !out_ready;
      prev_m = int'(m);
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Present a pair (aligned just after a rising edge) and hold it until accepted.
  task automatic send_pair(input logic [4:0] pa, input logic [4:0] pb);
    bit acc;
    int guard;
    a = pa; b = pb; in_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
      if (guard > 100) begin
        check_eq("send_pair_timeout", guard, 0);
        acc = 1'b1;
      end
    end
  endtask

  // Single pair into an empty pipeline, checking the exact three-edge latency.
  task automatic send_one(input logic [4:0] pa, input logic [4:0] pb, input int exp);
    a = pa; b = pb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check_eq("lat_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("lat_valid_e0", int'(out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("lat_valid_e1", int'(out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("lat_valid_e2", int'(out_valid), 1);
    check_eq("directed_m", int'(m), exp);
    @(posedge clk); #1;
  endtask

  task automatic send8(input logic [7:0] pa, input logic [7:0] pb, input int exp);
    a8 = pa; b8 = pb; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq("n8_valid", int'(out_valid8), 1);
    check_eq("n8_m", int'(m8), exp);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int bound);
    int cyc;
    cyc = 0;
    while ((sb.size() != 0 || out_valid) && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("drain_sb_empty", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset values while reset is held low.
    #12;
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_m", int'(m), 0);
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_m8", int'(m8), 0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, P = 29.
    send_one(5'd7, 5'd9, 5);
    send_one(5'd28, 5'd28, 1);
    send_one(5'd31, 5'd31, 4);
    send_one(5'd0, 5'd17, 0);

    // Directed vectors, P = 251.
    send8(8'd250, 8'd250, 1);
    send8(8'd255, 8'd255, 16);

    // Exhaustive back-to-back stream.
    mon_en = 1'b1; stream_mode = 1'b1; ir_drops = 0; base = rcv;
    for (int i = 0; i < 1024; i++) begin
      send_pair(5'(i >> 5), 5'(i));
    end
    in_valid = 1'b0;
    stream_mode = 1'b0;
    drain(20);
    check_eq("exh_in_ready_drops", ir_drops, 0);
    check_eq("exh_count", rcv - base, 1024);

    // Backpressure: stall output for 5 cycles starting with the 2nd result.
    stream_mode = 1'b1; ir_drops = 0; base = rcv;
    fork
      begin
        for (int i = 0; i < 6; i++) send_pair(5'(3 * i + 20), 5'(i + 25));
        in_valid = 1'b0;
      end
      begin
        int g;
        g = 0;
        while (rcv != base + 1 && g < 50) begin
          @(negedge clk);
          g++;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    stream_mode = 1'b0;
    drain(30);
    check_eq("bp_in_ready_low_cycles", ir_drops, 5);
    check_eq("bp_count", rcv - base, 6);

    // Random in_valid and out_ready.
    base = rcv; rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(1, 0) == 1) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          send_pair(5'($urandom), 5'($urandom));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = 1'($urandom_range(1, 0));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain(30);
    check_eq("rnd_count", rcv - base, 60);

    // Asynchronous reset with three pairs in flight.
    mon_en = 1'b0;
    out_ready = 1'b0;
    send_pair(5'd11, 5'd13);
    send_pair(5'd19, 5'd23);
    send_pair(5'd30, 5'd29);
    in_valid = 1'b0;
    @(negedge clk); #2;
    check_eq("pre_rst_out_valid", int'(out_valid), 1);
    reset = 1'b0;
    #1;
    check_eq("async_rst_out_valid", int'(out_valid), 0);
    check_eq("async_rst_m", int'(m), 0);
    check_eq("async_rst_in_ready", int'(in_ready), 1);
    sb.delete();
    #6 reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("post_rst_no_stale", int'(out_valid), 0);
    end
    @(posedge clk); #1;

`ifdef MODMUL_TAG_EN
    // Tags 0..F stream through the P=251 instance alongside their results.
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          a8 = 8'(240 + i); b8 = 8'(i + 3); in_tag8 = 4'(i); in_valid8 = 1'b1;
          @(posedge clk); #1;
        end
        in_valid8 = 1'b0;
      end
      begin
        int idx;
        idx = 0;
        for (int cyc = 0; cyc < 40 && idx < 16; cyc++) begin
          @(negedge clk);
          if (out_valid8) begin
            check_eq("tag_m", int'(m8), ((240 + idx) * (idx + 3)) % 251);
            check_eq("tag_out", int'(out_tag8), idx);
            idx++;
          end
        end
        check_eq("tag_count", idx, 16);
      end
    join
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/modmul_pm_pipe.md
Name: modmul_pm_pipe

Overview:
- Parametrised, fully pipelined modular multiplier: m = (a*b) mod P, pseudo-Mersenne modulus P = 2^N - C.
- Generalises the fixed 5-bit mod-29 pipeline to any N/C pair meeting the constraint below.
- Adds valid/ready handshaking with backpressure, one result per cycle sustained.
- Sits between operand producers and downstream arithmetic; interchangeable across moduli by parameter only.

Parameters:
- N, 5, operand/result width in bits; must be ≥ 3.
- C, 3, modulus offset, P = 2^N - C; must satisfy 1 ≤ C and C*(C+2) < 2^N. Elaboration fails otherwise.
- TAG_W, 4, sideband tag width; used only when MODMUL_TAG_EN is defined.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair this cycle
- a  in  N  operand, any N-bit value (values ≥ P allowed)
- b  in  N  operand, any N-bit value
- in_tag  in  TAG_W  sideband tag (MODMUL_TAG_EN only)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- m  out  N  canonical result, 0 ≤ m < P
- out_tag  out  TAG_W  tag of the accepted pair (MODMUL_TAG_EN only)

Behaviour:
- Reset: asynchronous assert while reset=0. All stage valid bits = 0, all data registers = 0. Outputs during and after reset: out_valid=0, m=0, out_tag=0, in_ready=1. In-flight data is discarded; no partial results after deassertion.
- Three register stages, each holding {valid, data}:
  - S1: prod = a*b, 2N bits.
  - S2: f1 = prod[N-1:0] + C*prod[2N-1:N], width N + clog2(C+1) + 1.
  - S3: f2 = f1[N-1:0] + C*f1[MSB:N]; m = (f2 ≥ P) ? f2 - P : f2, registered.
- The C constraint guarantees f2 < 2P, so a single conditional subtract is sufficient.
- m and out_valid come directly from S3 registers; no combinational path from a/b to m.
- Handshake:
  - Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready.
  - ready3 = ~v3 | out_ready; ready2 = ~v2 | ready3; in_ready = ~v1 | ready2.
  - The ready chain is combinational from out_ready to in_ready; this path is required.
- Stage k loads from stage k-1 when ready_k=1. Its valid becomes the upstream valid, so bubbles propagate. When ready_k=0, stage k holds its data and valid.
- Latency: a pair accepted at edge E0 is in S1 after E0, S2 after E1, and appears on m with out_valid=1 after E2, provided out_ready stays high.
- Throughput: 1 pair/cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, m and out_tag stay stable. Upstream stages fill, then in_ready drops once S1..S3 are all valid. At most 3 pairs are held; none are lost or duplicated.
- Simultaneous output and input transfer at a full pipeline: all stages shift, occupancy is unchanged, in_ready=1.
- in_valid=0: a bubble enters S1, and data registers may update freely. Only valid-qualified data is meaningful.
- Operand a or b equal to 2^N-1 or ≥ P is reduced correctly; the result is always < P.
- Results are in strict acceptance order.

Optional Feature:
- Macro MODMUL_TAG_EN.
- Defined: ports in_tag/out_tag exist. Each tag travels through S1..S3 with its operand pair and is presented on out_tag together with m under the same stall/hold rules. Tag reset value is 0.
- Undefined: tag ports and tag registers are absent. Datapath and handshake behaviour are identical.

Decomposition:
- Shared package modmul_pkg:
  - function pm_fold(width-generic: lo + C*hi);
  - localparams P, F1_W, F2_W derived from N and C;
  - the C-constraint check function.
- One natural sub-module: modmul_pipe_stage, a parametrised {valid, data} register with the ready/hold logic, instantiated three times.
- The arithmetic lives in the top module.

Test Plan:
- Defaults (N=5, C=3, P=29): a=7, b=9 accepted, out_ready=1 -> m=5, out_valid=1 after 3rd edge counting the acceptance edge; a=28, b=28 -> m=1; a=31, b=31 -> m=4; a=0, b=17 -> m=0.
- Exhaustive streaming at defaults: all 1024 pairs back-to-back, out_ready=1 -> in_ready constantly 1, 1024 results in order, each equal to (a*b)%29.
- Backpressure: stream 6 pairs, hold out_ready=0 from the 2nd result for 5 cycles -> in_ready falls once 3 are held, m stable during the stall, order preserved, no drops.
- Random out_ready at 50% with random in_valid -> scoreboard matches, out_valid never drops without an out transfer.
- Reset mid-operation: assert reset=0 asynchronously with 3 pairs in flight -> out_valid=0 and m=0 immediately, in_ready=1; no stale result after release.
- N=8, C=5 (P=251): a=250, b=250 -> m=1; a=255, b=255 -> m=16. With MODMUL_TAG_EN, tags 0..F must emerge on out_tag aligned with their results.
